// File: rtl/uart_tx.sv
// uart_tx: transmit half of the UART.
// Pops bytes from a first-word-fall-through TX queue and serialises each one
// as start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop
// bits. Bit timing is OVERSAMPLE ticks of tx_clk_en per bit.
// Optional feature: define UART_TX_BREAK_EN to add line-break generation
// (send_break holds the line low, followed by one bit time of mark).
module uart_tx #(
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_clk_en,
   input  logic       parity_en,
   input  logic       parity_odd,
   input  logic       double_stop_bit,
   input  logic       tx_queue_empty,
   input  logic [7:0] tx_queue_data,
   input  logic       send_break,
   output logic       tx_queue_re,
   output logic       tx,
   output logic       tx_busy
);

   localparam int CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP1,
      S_STOP2
`ifdef UART_TX_BREAK_EN
      ,
      S_BREAK,
      S_MARK
`endif
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       bit_q;
   logic [7:0]       shift_q;
   logic             par_q;
   logic             par_en_q;
   logic             par_odd_q;
   logic             dbl_stop_q;
   logic             tx_q;
   logic             busy_q;

   logic             bit_end_d;
   logic             final_end_d;
   logic             break_req_d;
   logic             load_d;

`ifdef UART_TX_BREAK_EN
   // A break request is only honoured while the line is idle.
   always_comb begin
      break_req_d = (state_q == S_IDLE) && send_break;
   end
`else
   logic unused_send_break;
   assign unused_send_break = send_break;

   // Without the break feature the request input is ignored.
   always_comb begin
      break_req_d = 1'b0;
   end
`endif

   // Decode bit boundaries and the pop condition for the current tick.
   always_comb begin
      bit_end_d   = tx_clk_en && (cnt_q == CNT_LAST);
      final_end_d = bit_end_d &&
                    (((state_q == S_STOP1) && !dbl_stop_q) || (state_q == S_STOP2));
      load_d      = tx_clk_en && !tx_queue_empty &&
                    (((state_q == S_IDLE) && !break_req_d) || final_end_d);
   end

   // Pop strobe is combinational so the head byte is sampled in the same cycle.
   assign tx_queue_re = load_d && !reset;
   assign tx          = tx_q;
   assign tx_busy     = busy_q;

   // Controller FSM: state, bit-time counter, shift register, parity, outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         par_en_q   <= 1'b0;
         par_odd_q  <= 1'b0;
         dbl_stop_q <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else if (tx_clk_en) begin
         if (load_d) begin
            // Load from idle or back-to-back from the final stop bit.
            state_q    <= S_START;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= tx_queue_data;
            par_q      <= 1'b0;
            par_en_q   <= parity_en;
            par_odd_q  <= parity_odd;
            dbl_stop_q <= double_stop_bit;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  cnt_q  <= '0;
                  tx_q   <= 1'b1;
                  busy_q <= 1'b0;
`ifdef UART_TX_BREAK_EN
                  if (send_break) begin
                     state_q <= S_BREAK;
                     tx_q    <= 1'b0;
                     busy_q  <= 1'b1;
                  end
`endif
               end
               S_START: begin
                  if (bit_end_d) begin
                     state_q <= S_DATA;
                     cnt_q   <= '0;
                     bit_q   <= '0;
                     tx_q    <= shift_q[0];
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               S_DATA: begin
                  if (bit_end_d) begin
                     cnt_q   <= '0;
                     par_q   <= par_q ^ shift_q[0];
                     shift_q <= shift_q >> 1;
                     bit_q   <= bit_q + 3'd1;
                     if (bit_q == 3'd7) begin
                        if (par_en_q) begin
                           state_q <= S_PARITY;
                           tx_q    <= par_q ^ shift_q[0] ^ par_odd_q;
                        end else begin
                           state_q <= S_STOP1;
                           tx_q    <= 1'b1;
                        end
                     end else begin
                        tx_q <= shift_q[1];
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               S_PARITY: begin
                  if (bit_end_d) begin
                     state_q <= S_STOP1;
                     cnt_q   <= '0;
                     tx_q    <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               S_STOP1: begin
                  if (bit_end_d) begin
                     cnt_q <= '0;
                     tx_q  <= 1'b1;
                     if (dbl_stop_q) begin
                        state_q <= S_STOP2;
                     end else begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                     end
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               S_STOP2: begin
                  if (bit_end_d) begin
                     state_q <= S_IDLE;
                     cnt_q   <= '0;
                     tx_q    <= 1'b1;
                     busy_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
`ifdef UART_TX_BREAK_EN
               S_BREAK: begin
                  cnt_q <= '0;
                  if (!send_break) begin
                     state_q <= S_MARK;
                     tx_q    <= 1'b1;
                  end
               end
               S_MARK: begin
                  if (bit_end_d) begin
                     state_q <= S_IDLE;
                     cnt_q   <= '0;
                     busy_q  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
`endif
               default: begin
                  state_q <= S_IDLE;
                  cnt_q   <= '0;
                  tx_q    <= 1'b1;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Transmit half of the UART. Pops bytes from the TX queue (first-word-fall-through FIFO) and serialises each one onto `tx` as an asynchronous frame: start bit, 8 data bits LSB first, optional parity bit, then 1 or 2 stop bits. Bit timing derives from the same oversampling clock enable that drives the receiver. Controller FSM, bit-time counter, shift register and parity logic are all in this block.

## Interface

**Parameters**
- `OVERSAMPLE`, default 16: `tx_clk_en` ticks per bit; must be ≥ 2.

**Ports**
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `tx_clk_en` in 1: oversample tick, one `clk` cycle wide.
- `parity_en` in 1: append a parity bit.
- `parity_odd` in 1: 1 = odd parity, 0 = even parity.
- `double_stop_bit` in 1: 1 = two stop bits, 0 = one.
- `tx_queue_empty` in 1: queue has no data.
- `tx_queue_data` in 8: head of queue; valid while `!tx_queue_empty`.
- `send_break` in 1: request a line break (see Configuration).
- `tx_queue_re` out 1: pop strobe, one `clk` cycle wide.
- `tx` out 1: serial line, registered, idles high.
- `tx_busy` out 1: a frame or break is in progress.

## Operation

- **Tick gating.** All state, counter and shift-register updates occur only in cycles where `tx_clk_en` = 1. `tx_queue_re` is asserted only in such cycles.
- **Bit-time counter.** Cleared on every state change. Counts ticks 0..`OVERSAMPLE`-1. A bit ends on the tick where count = `OVERSAMPLE`-1.
- **States:**
  - `IDLE`: `tx`=1. On a tick with `!tx_queue_empty`:
    - assert `tx_queue_re`;
    - load the shift register with `tx_queue_data`;
    - latch `parity_en`, `parity_odd` and `double_stop_bit`;
    - clear the parity accumulator;
    - go to `START`.
  - `START`: `tx`=0 for one bit time, then go to `DATA`. The data-bit counter clears.
  - `DATA`: `tx` = shift[0].
    - At the end of each bit: XOR shift[0] into the parity accumulator, shift right, and increment the bit counter.
    - After bit 7 ends, go to `PARITY` if parity is latched on, else `STOP1`.
  - `PARITY`: `tx` = accumulator XOR latched `parity_odd`, for one bit time, then go to `STOP1`.
  - `STOP1`: `tx`=1 for one bit time.
    - If `double_stop_bit` is latched, go to `STOP2`.
    - Otherwise this is the final stop bit (see below).
  - `STOP2`: `tx`=1 for one bit time; this is the final stop bit.
  - **End of the final stop bit:**
    - If `!tx_queue_empty` on that tick: pop and load exactly as in `IDLE`, then go directly to `START` (back-to-back frames, no idle gap).
    - Otherwise go to `IDLE`.
- **Config latching.** Configuration inputs are used only as latched at load. Changing them mid-frame does not affect the current frame.
- **`tx_busy`** = 1 in every state except `IDLE`.
- **Reset.**
  - On reset: `tx`=1, `tx_busy`=0, `tx_queue_re`=0, state `IDLE`, all counters cleared.
  - Reset mid-frame aborts the frame. `tx` returns high at the next edge and the aborted byte is not re-sent.
- **Queue becoming empty.** `tx_queue_empty` asserting during a frame has no effect until the final stop bit ends.

## Timing

- **Load to start bit.** `tx` falls at the `clk` edge that ends the load cycle (the cycle with `tx_queue_re`=1). `tx` is registered, so it changes one `clk` after the controlling tick.
- **Frame length** = (1 + 8 + P + S) × `OVERSAMPLE` ticks, where P = parity bit (0 or 1) and S = stop bits (1 or 2).
- **`tx_queue_re`** is high for exactly one `clk` cycle per byte. Data is sampled in that same cycle.
- **Back-to-back frames.** The next start bit begins one tick after the previous final stop-bit tick, with no extra bit time between frames.

## Configuration

- **Macro:** `UART_TX_BREAK_EN`.
- **Defined:** adds state `BREAK`.
  - In `IDLE` with `send_break`=1, `send_break` has priority over a queue pop. Go to `BREAK` with `tx`=0 and `tx_busy`=1.
  - Hold `BREAK` while `send_break`=1.
  - After release, drive `tx`=1 for one bit time (mark-after-break), then go to `IDLE`.
  - `send_break` is ignored outside `IDLE`.
- **Undefined:** the `send_break` port remains present but is ignored, and `BREAK` does not exist.

## Test plan

- **Single frame.** `OVERSAMPLE`=16, `tx_clk_en` tied high, queue holds 0xA5, no parity, 1 stop bit.
  - `tx` = 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles.
  - `tx_queue_re` pulses once.
  - `tx_busy` is high for 160 cycles, then `tx`=1 idle.
- **Parity.** Byte 0x07, `parity_en`=1.
  - Even parity: parity bit = 1.
  - Odd parity: parity bit = 0.
  - Frame is 176 cycles.
- **Double stop, back-to-back.** `double_stop_bit`=1, queue holds 0x00 then 0xFF.
  - Stop level lasts 32 cycles.
  - Second start bit follows immediately.
  - Exactly 2 pops; `tx_busy` never drops between the frames.
- **Sparse tick and config change.** `tx_clk_en` every 4th cycle; toggle `parity_en` mid-frame.
  - Each bit lasts 64 cycles.
  - The frame keeps its load-time config.
- **Reset mid-frame.** Assert `reset` during data bit 3.
  - Next edge: `tx`=1, `tx_busy`=0, no pop.
  - A new byte afterwards transmits correctly.
- **Break (with `UART_TX_BREAK_EN`).** `send_break` held for 100 ticks with the queue non-empty.
  - `tx`=0 for 100 ticks, then 1 for 16 ticks.
  - Then the queued byte is sent.
